// File: rtl/udp_tx_frame_fifo_if.sv
// AXI4-Stream bundle used for both the packetiser-side and the MAC-side ports of udp_tx_frame_fifo.
interface udp_tx_frame_fifo_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic                  tuser;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/udp_tx_frame_fifo.sv
// Store-and-forward frame FIFO: a frame is released to the MAC only after its last beat is stored.
// Define UDP_TX_FIFO_ERR_DROP_EN to drop frames flagged with tuser on their tlast beat.
module udp_tx_frame_fifo #(
    parameter int DATA_WIDTH  = 64,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int DEPTH_LOG2  = 11,
    parameter int FRAMES_LOG2 = 5
) (
    input  logic                     axis_aclk,
    input  logic                     axis_aresetn,
    udp_tx_frame_fifo_if.slave       s_axis,
    udp_tx_frame_fifo_if.master      m_axis,
    output logic [DEPTH_LOG2:0]      fill_level,
    output logic [FRAMES_LOG2-1:0]   frames_stored,
    output logic                     drop_pulse
);
    localparam int WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]    FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]    PTR_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [FRAMES_LOG2-1:0] FRAMES_MAX = '1;
    localparam logic [FRAMES_LOG2-1:0] FRAME_ONE  = FRAMES_LOG2'(1);

    typedef enum logic [1:0] {IDLE, STORE, DISCARD} wr_state_t;

    wr_state_t               state_reg, state_next;
    logic [DEPTH_LOG2:0]     wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2:0]     wr_commit_reg, wr_commit_next;
    logic [DEPTH_LOG2:0]     rd_ptr_reg;
    logic [DEPTH_LOG2:0]     ptr_diff;
    logic [FRAMES_LOG2-1:0]  frames_reg;
    logic                    drop_reg, drop_next;
    logic                    ready_en_reg;
    logic                    full, s_ready, s_accept, wr_en, commit;
    logic                    err_last, wr_user;

    logic [WORD_WIDTH-1:0]   mem [DEPTH];
    logic [WORD_WIDTH-1:0]   wr_word, ram_q;
    logic                    rd_issue, rd_inflight_reg, pop, rd_done;
    logic [1:0]              out_count_reg;
    logic [2:0]              occ_after;
    logic [WORD_WIDTH-1:0]   head_reg, tail_reg;

`ifdef UDP_TX_FIFO_ERR_DROP_EN
    assign err_last = s_axis.tuser;
    assign wr_user  = 1'b0;
`else
    assign err_last = 1'b0;
    assign wr_user  = s_axis.tuser;
`endif

    assign ptr_diff = wr_ptr_reg - rd_ptr_reg;
    assign full     = (ptr_diff == FULL_COUNT);
    // ready_en_reg keeps tready low until the first clock edge after reset release
    assign s_ready  = (state_reg == DISCARD) ||
                      (ready_en_reg && !full && (state_reg == STORE || frames_reg != FRAMES_MAX));
    assign s_accept = s_axis.tvalid && s_ready;
    assign wr_word  = {wr_user, s_axis.tlast, s_axis.tkeep, s_axis.tdata};

    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        wr_commit_next = wr_commit_reg;
        drop_next      = 1'b0;
        commit         = 1'b0;
        wr_en          = 1'b0;
        case (state_reg)
            IDLE, STORE: begin
                if (s_accept) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = wr_ptr_reg + PTR_ONE;
                    state_next  = STORE;
                    if (s_axis.tlast) begin
                        state_next = IDLE;
                        if (err_last) begin
                            wr_ptr_next = wr_commit_reg;
                            drop_next   = 1'b1;
                        end else begin
                            wr_commit_next = wr_ptr_reg + PTR_ONE;
                            commit         = 1'b1;
                        end
                    end
                end else if (state_reg == STORE && full && frames_reg == '0) begin
                    // Nothing committed can drain, so this frame can never fit.
                    state_next  = DISCARD;
                    wr_ptr_next = wr_commit_reg;
                    drop_next   = 1'b1;
                end
            end
            DISCARD: begin
                if (s_accept && s_axis.tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            wr_commit_reg <= '0;
            drop_reg      <= 1'b0;
            ready_en_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            wr_commit_reg <= wr_commit_next;
            drop_reg      <= drop_next;
            ready_en_reg  <= 1'b1;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= wr_word;
        end
        if (rd_issue) begin
            ram_q <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
        end
    end

    // Only fetch when the skid pair plus the word in flight out of the RAM still fits.
    assign pop       = (out_count_reg != 2'd0) && m_axis.tready;
    assign rd_done   = pop && head_reg[WORD_WIDTH-2];
    assign occ_after = 3'(out_count_reg) + 3'(rd_inflight_reg) - 3'(pop);
    assign rd_issue  = (rd_ptr_reg != wr_commit_reg) && (occ_after < 3'd2);

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            rd_ptr_reg      <= '0;
            rd_inflight_reg <= 1'b0;
            out_count_reg   <= 2'd0;
            head_reg        <= '0;
            tail_reg        <= '0;
            frames_reg      <= '0;
        end else begin
            rd_ptr_reg      <= rd_ptr_reg + (DEPTH_LOG2 + 1)'(rd_issue);
            rd_inflight_reg <= rd_issue;
            out_count_reg   <= out_count_reg + 2'(rd_inflight_reg) - 2'(pop);
            if (pop) begin
                if (out_count_reg == 2'd2) begin
                    head_reg <= tail_reg;
                end else if (rd_inflight_reg) begin
                    head_reg <= ram_q;
                end
            end else if (out_count_reg == 2'd0 && rd_inflight_reg) begin
                head_reg <= ram_q;
            end
            if (rd_inflight_reg && ((out_count_reg == 2'd1 && !pop) || (out_count_reg == 2'd2 && pop))) begin
                tail_reg <= ram_q;
            end
            case ({commit, rd_done})
                2'b10:   frames_reg <= frames_reg + FRAME_ONE;
                2'b01:   frames_reg <= frames_reg - FRAME_ONE;
                default: ;
            endcase
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = head_reg[DATA_WIDTH-1:0];
    assign m_axis.tkeep  = head_reg[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis.tlast  = head_reg[WORD_WIDTH-2];
    assign m_axis.tuser  = head_reg[WORD_WIDTH-1];
    assign m_axis.tvalid = (out_count_reg != 2'd0);
    assign fill_level    = ptr_diff;
    assign frames_stored = frames_reg;
    assign drop_pulse    = drop_reg;
endmodule

// File: tb/tb_udp_tx_frame_fifo.sv
// Directed self-checking bench for udp_tx_frame_fifo: one task per scenario, one line per transaction.
`timescale 1ns/1ps
module tb_udp_tx_frame_fifo;
    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk = 1'b0;
    logic        axis_aresetn;
    logic [11:0] fill_level;
    logic [4:0]  frames_stored;
    logic        drop_pulse;

    udp_tx_frame_fifo_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) s_if ();
    udp_tx_frame_fifo_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) m_if ();

    udp_tx_frame_fifo #(
        .DATA_WIDTH(64), .KEEP_WIDTH(8), .DEPTH_LOG2(11), .FRAMES_LOG2(5)
    ) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (axis_aresetn),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .fill_level    (fill_level),
        .frames_stored (frames_stored),
        .drop_pulse    (drop_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int epoch = 0;
    int mark_idx = -1;
    int mark_edge = -1;
    int last_edge = -1;

    // Monitor state, written only by the monitor process.
    beat_t out_q[$];
    int    seen_epoch = 0;
    int    first_valid_cyc = -1;
    int    drop_cnt = 0;
    int    drop_cyc = -1;
    int    peak_fs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        beat_t b;
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            out_q.delete();
            first_valid_cyc = -1;
            drop_cnt = 0;
            drop_cyc = -1;
            peak_fs = 0;
        end
        if (m_if.tvalid && m_if.tready) begin
            b.d = m_if.tdata; b.k = m_if.tkeep; b.l = m_if.tlast; b.u = m_if.tuser;
            out_q.push_back(b);
        end
        if (m_if.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (drop_pulse) begin
            drop_cnt = drop_cnt + 1;
            if (drop_cyc < 0) drop_cyc = cyc;
        end
        if (int'(frames_stored) > peak_fs) peak_fs = int'(frames_stored);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic beat_t make_beat(input int fid, input int i, input int len, input bit err);
        beat_t b;
        b.d = {8'hA5, fid[7:0], 16'(len), 32'(i)};
        b.l = (i == len - 1);
        b.k = b.l ? 8'h3F : 8'hFF;
        b.u = err && b.l;
        return b;
    endfunction

    task automatic drive_beat(input beat_t b);
        s_if.tdata = b.d; s_if.tkeep = b.k; s_if.tlast = b.l; s_if.tuser = b.u; s_if.tvalid = 1'b1;
    endtask

    task automatic send_frame(input int fid, input int n_send, input int len, input bit err);
        bit rdy, ok;
        int e;
        for (int i = 0; i < n_send; i++) begin
            drive_beat(make_beat(fid, i, len, err));
            ok = 1'b0;
            e = 0;
            for (int w = 0; w < 4000; w++) begin
                @(negedge clk); rdy = s_if.tready; e = cyc + 1;
                @(posedge clk); #1;
                if (rdy) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL send_timeout frame %0d beat %0d: tready stayed 0, required 1 within 4000 cycles", fid, i);
                break;
            end
            last_edge = e;
            if (i == mark_idx) mark_edge = e;
        end
        s_if.tvalid = 1'b0;
        $display("sent frame %0d: %0d of %0d beats, last accept edge %0d", fid, n_send, len, last_edge);
    endtask

    task automatic wait_out(input int n);
        for (int w = 0; w < 6000; w++) begin
            @(negedge clk);
            if (out_q.size() >= n) break;
        end
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        m_if.tready = 1'b1;
        axis_aresetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); axis_aresetn = 1'b1;
        @(posedge clk); #1;
        epoch++;
        mark_idx = -1; mark_edge = -1;
    endtask

    task automatic test_reset();
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        m_if.tready = 1'b1;
        axis_aresetn = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata, m_if.tkeep} !== 75'd0) begin
            errors++; $display("FAIL reset_m_outputs: got valid=%b data=%h keep=%h, required all 0", m_if.tvalid, m_if.tdata, m_if.tkeep);
        end
        checks++;
        if ({fill_level, frames_stored, drop_pulse, s_if.tready} !== 19'd0) begin
            errors++; $display("FAIL reset_status: got fill=%0d frames=%0d drop=%b ready=%b, required all 0", fill_level, frames_stored, drop_pulse, s_if.tready);
        end
        @(negedge clk); axis_aresetn = 1'b1; #1;
        checks++;
        if (s_if.tready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_before_edge: got %b, required 0", s_if.tready);
        end
        @(posedge clk); #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after_edge: got %b, required 1", s_if.tready);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        beat_t exp_b;
        do_reset();
        send_frame(1, 1032, 1032, 1'b0);
        wait_out(1032);
        checks++;
        if (first_valid_cyc - last_edge !== 2) begin
            errors++; $display("FAIL single_latency: got %0d edges, required 2", first_valid_cyc - last_edge);
        end
        checks++;
        if (out_q.size() !== 1032) begin
            errors++; $display("FAIL single_count: got %0d beats, required 1032", out_q.size());
        end
        for (int i = 0; i < 1032 && i < out_q.size(); i++) begin
            exp_b = make_beat(1, i, 1032, 1'b0);
            checks++;
            if (out_q[i] !== exp_b) begin
                errors++; $display("FAIL single_data beat %0d: got %h, required %h", i, out_q[i], exp_b);
                break;
            end
        end
        checks++;
        if (out_q.size() == 1032 && out_q[1031].l !== 1'b1) begin
            errors++; $display("FAIL single_tlast: got %b on beat 1031, required 1", out_q[1031].l);
        end
        checks++;
        if (fill_level !== 12'd0 || frames_stored !== 5'd0) begin
            errors++; $display("FAIL single_fill_end: got fill=%0d frames=%0d, required 0/0", fill_level, frames_stored);
        end
        $display("test_single_frame: %0d beats out", out_q.size());
    endtask

    task automatic test_back_to_back();
        beat_t exp_b, snap;
        bit snap_v;
        int unstable;
        do_reset();
        unstable = 0;
        fork
            begin
                send_frame(10, 1032, 1032, 1'b0);
                send_frame(11, 1032, 1032, 1'b0);
                send_frame(12, 1032, 1032, 1'b0);
            end
            begin
                for (int w = 0; w < 5000; w++) begin
                    @(posedge clk); #1;
                    if (out_q.size() >= 1532) break;
                end
                m_if.tready = 1'b0;
                @(negedge clk);
                snap_v = m_if.tvalid;
                snap = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
                for (int c = 0; c < 500; c++) begin
                    @(negedge clk);
                    if (m_if.tvalid !== 1'b1 || {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !== snap) unstable++;
                end
                checks++;
                if (snap_v !== 1'b1 || unstable !== 0) begin
                    errors++; $display("FAIL bp_stall_stable: got valid=%b, %0d changed cycles, required valid=1 and 0 changes", snap_v, unstable);
                end
                @(posedge clk); #1;
                m_if.tready = 1'b1;
            end
        join
        wait_out(3 * 1032);
        checks++;
        if (out_q.size() !== 3 * 1032) begin
            errors++; $display("FAIL bp_count: got %0d beats, required 3096", out_q.size());
        end
        for (int i = 0; i < 3 * 1032 && i < out_q.size(); i++) begin
            exp_b = make_beat(10 + i / 1032, i % 1032, 1032, 1'b0);
            checks++;
            if (out_q[i] !== exp_b) begin
                errors++; $display("FAIL bp_data beat %0d: got %h, required %h", i, out_q[i], exp_b);
                break;
            end
        end
        checks++;
        if (peak_fs !== 2) begin
            errors++; $display("FAIL bp_frames_peak: got %0d, required 2", peak_fs);
        end
        $display("test_back_to_back: %0d beats out, frames_stored peak %0d", out_q.size(), peak_fs);
    endtask

    task automatic test_full_committed();
        beat_t exp_b;
        bit seen;
        do_reset();
        m_if.tready = 1'b0;
        fork
            begin
                send_frame(20, 1032, 1032, 1'b0);
                send_frame(21, 1032, 1032, 1'b0);
            end
            begin
                seen = 1'b0;
                for (int w = 0; w < 5000; w++) begin
                    @(negedge clk);
                    if (s_if.tvalid && !s_if.tready) begin seen = 1'b1; break; end
                end
                checks++;
                if (!seen || fill_level !== 12'd2048) begin
                    errors++; $display("FAIL full_level: got stall=%b fill=%0d, required stall=1 fill=2048", seen, fill_level);
                end
                repeat (10) @(negedge clk);
                checks++;
                if (s_if.tready !== 1'b0 || frames_stored !== 5'd1 || drop_cnt !== 0) begin
                    errors++; $display("FAIL full_hold: got ready=%b frames=%0d drops=%0d, required 0/1/0", s_if.tready, frames_stored, drop_cnt);
                end
                @(posedge clk); #1;
                m_if.tready = 1'b1;
            end
        join
        wait_out(2 * 1032);
        checks++;
        if (out_q.size() !== 2 * 1032 || drop_cnt !== 0) begin
            errors++; $display("FAIL full_count: got %0d beats %0d drops, required 2064 beats 0 drops", out_q.size(), drop_cnt);
        end
        for (int i = 0; i < 2 * 1032 && i < out_q.size(); i++) begin
            exp_b = make_beat(20 + i / 1032, i % 1032, 1032, 1'b0);
            checks++;
            if (out_q[i] !== exp_b) begin
                errors++; $display("FAIL full_data beat %0d: got %h, required %h", i, out_q[i], exp_b);
                break;
            end
        end
        $display("test_full_committed: %0d beats out", out_q.size());
    endtask

    task automatic test_oversize();
        beat_t exp_b;
        do_reset();
        mark_idx = 2047;
        send_frame(30, 2100, 2100, 1'b0);
        repeat (10) @(posedge clk); #1;
        checks++;
        if (drop_cnt !== 1 || drop_cyc !== mark_edge + 1) begin
            errors++; $display("FAIL oversize_drop: got %0d pulses at edge %0d, required 1 pulse at edge %0d", drop_cnt, drop_cyc, mark_edge + 1);
        end
        checks++;
        if (out_q.size() !== 0 || fill_level !== 12'd0) begin
            errors++; $display("FAIL oversize_nothing_out: got %0d beats fill=%0d, required 0/0", out_q.size(), fill_level);
        end
        send_frame(31, 100, 100, 1'b0);
        wait_out(100);
        checks++;
        if (out_q.size() !== 100) begin
            errors++; $display("FAIL oversize_next_count: got %0d beats, required 100", out_q.size());
        end
        for (int i = 0; i < 100 && i < out_q.size(); i++) begin
            exp_b = make_beat(31, i, 100, 1'b0);
            checks++;
            if (out_q[i] !== exp_b) begin
                errors++; $display("FAIL oversize_next_data beat %0d: got %h, required %h", i, out_q[i], exp_b);
                break;
            end
        end
        $display("test_oversize: drop at edge %0d, next frame %0d beats out", drop_cyc, out_q.size());
    endtask

    task automatic test_err_flag();
        beat_t exp_b;
        do_reset();
        send_frame(40, 64, 64, 1'b1);
        repeat (80) @(posedge clk); #1;
`ifdef UDP_TX_FIFO_ERR_DROP_EN
        checks++;
        if (drop_cnt !== 1 || out_q.size() !== 0) begin
            errors++; $display("FAIL err_drop: got %0d pulses %0d beats, required 1 pulse 0 beats", drop_cnt, out_q.size());
        end
`else
        checks++;
        if (drop_cnt !== 0 || out_q.size() !== 64) begin
            errors++; $display("FAIL err_forward: got %0d pulses %0d beats, required 0 pulses 64 beats", drop_cnt, out_q.size());
        end
        for (int i = 0; i < 64 && i < out_q.size(); i++) begin
            exp_b = make_beat(40, i, 64, 1'b1);
            checks++;
            if (out_q[i] !== exp_b) begin
                errors++; $display("FAIL err_data beat %0d: got %h, required %h", i, out_q[i], exp_b);
                break;
            end
        end
`endif
        checks++;
        if (fill_level !== 12'd0) begin
            errors++; $display("FAIL err_fill_end: got %0d, required 0", fill_level);
        end
        $display("test_err_flag: %0d beats out, %0d drops", out_q.size(), drop_cnt);
    endtask

    task automatic test_async_reset();
        do_reset();
        m_if.tready = 1'b0;
        send_frame(50, 10, 10, 1'b0);
        send_frame(51, 300, 1032, 1'b0);
        checks++;
        if (m_if.tvalid !== 1'b1 || frames_stored !== 5'd1) begin
            errors++; $display("FAIL areset_pre: got valid=%b frames=%0d, required 1/1", m_if.tvalid, frames_stored);
        end
        drive_beat(make_beat(51, 300, 1032, 1'b0));
        #2 axis_aresetn = 1'b0;
        #1;
        checks++;
        if ({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata, m_if.tkeep} !== 75'd0) begin
            errors++; $display("FAIL areset_m_outputs: got valid=%b data=%h, required all 0", m_if.tvalid, m_if.tdata);
        end
        checks++;
        if ({fill_level, frames_stored, drop_pulse, s_if.tready} !== 19'd0) begin
            errors++; $display("FAIL areset_status: got fill=%0d frames=%0d drop=%b ready=%b, required all 0", fill_level, frames_stored, drop_pulse, s_if.tready);
        end
        s_if.tvalid = 1'b0;
        @(negedge clk); axis_aresetn = 1'b1; #1;
        checks++;
        if (s_if.tready !== 1'b0) begin
            errors++; $display("FAIL areset_ready_before_edge: got %b, required 0", s_if.tready);
        end
        @(posedge clk); #1;
        checks++;
        if (s_if.tready !== 1'b1 || fill_level !== 12'd0) begin
            errors++; $display("FAIL areset_after_edge: got ready=%b fill=%0d, required 1/0", s_if.tready, fill_level);
        end
        m_if.tready = 1'b1;
        repeat (5) @(posedge clk); #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || frames_stored !== 5'd0) begin
            errors++; $display("FAIL areset_lost: got valid=%b frames=%0d, required 0/0", m_if.tvalid, frames_stored);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_full_committed();
        test_oversize();
        test_err_flag();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
